lock_arb_master: RTL and testbench
==================================

// Module: lock_arb_master
// PURPOSE
//  Clocked round-robin arbiter and 4-phase handshake master that sits directly upstream of the async
//  locker control stage. It picks one of N_REQ synchronous requesters and asserts lock and hs_req into
//  the locker's lock/req_in inputs. It synchronizes the locker's ack back into the clock domain and
//  completes one full return-to-zero handshake per grant.
// PARAMETERS
//  N_REQ        4     number of requesters (>=2)
//  SYNC_STAGES  2     flop stages on hs_ack synchronizer (>=2)
//  TIMEOUT_CYC  255   wait-state cycles before err sets (>=1); counter width $clog2(TIMEOUT_CYC+1)
// PORTS
//  clk      in   1      system clock, rising edge
//  rst      in   1      asynchronous reset, active-high
//  req_vec  in   N_REQ  level requests, one per requester
//  gnt_vec  out  N_REQ  one-hot grant, held for whole transaction
//  done     out  1      1-cycle pulse when granted transaction completes
//  lock     out  1      to locker lock input
//  hs_req   out  1      to locker req_in
//  hs_ack   in   1      from locker ack_in (asynchronous, = req_out | lock)
//  busy     out  1      1 whenever state != IDLE
//  err      out  1      sticky timeout flag, cleared only by rst
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; gnt_vec=0, done=0, lock=0, hs_req=0, busy=0, err=0;
//   rr pointer=0 (index 0 highest priority); sync chain=0; timeout counter=0. All outputs registered.
//  ack_s = hs_ack after SYNC_STAGES flops; the FSM uses only ack_s.
//  FSM (one transition per clk):
//   IDLE    : if |req_vec && ack_s==0 -> GRANT; gnt_vec<=winner. Otherwise stay.
//             If ack_s==1 (stale ack), do not grant.
//   GRANT   : lock<=1 -> REQ (lock rises 1 cycle after gnt)
//   REQ     : hs_req<=1 -> WAIT_HI
//   WAIT_HI : wait ack_s==1 -> DROP
//   DROP    : hs_req<=0, lock<=0 (same edge) -> WAIT_LO. Both are dropped together because
//             ack = req_out|lock cannot fall while lock is high.
//   WAIT_LO : wait ack_s==0 -> DONE
//   DONE    : gnt_vec<=0; done<=1 for this cycle only; rr pointer<=(winner+1)%N_REQ -> IDLE
//  Latency, with hs_ack immediate: IDLE->done high = 5 + 2*SYNC_STAGES cycles. Back-to-back
//   grants: next GRANT no earlier than 1 cycle after DONE.
//  Arbitration: winner = first set bit scanning from rr pointer upward, with wrap-around
//   N_REQ-1 -> 0. Winner is sampled only in IDLE; req_vec changes during a transaction are ignored.
//  Requester drops its req mid-transaction: the handshake still completes and done still pulses.
//  Timeout: counter clears on entry to WAIT_HI/WAIT_LO and increments each cycle spent waiting.
//   At count==TIMEOUT_CYC, err<=1 (sticky). Counter saturates. FSM keeps waiting with no abort.
//  hs_ack glitches shorter than one clk may be missed; this is legal because the locker holds its level.
//  rst asserted mid-transaction: lock/hs_req drop asynchronously and the locker returns to 0 via its own rst.
// TESTING
//  1 reset: rst=1 with req_vec=4'hF -> all outputs 0; after release, gnt_vec=4'b0001 one cycle
//    after first IDLE sample.
//  2 single txn: req_vec=4'b0100, hs_ack follows req|lock with 0 delay, SYNC_STAGES=2
//    -> gnt_vec=4'b0100; lock then hs_req; done pulse 9 cycles after IDLE sample.
//  3 round-robin: req_vec held 4'hF over 5 txns -> grant order 0,1,2,3,0.
//    Also req_vec=4'b1001 after a grant to 3 -> grant 0 (wrap-around).
//  4 stale ack: hs_ack=1 in IDLE with req_vec=1 -> no grant until ack_s==0, then grant next cycle.
//  5 timeout: TIMEOUT_CYC=8, hs_ack stuck 0 -> err=1 after 8 WAIT_HI cycles.
//    FSM stays in WAIT_HI; raising hs_ack then completes the txn with err still 1.
//  6 mid-op reset: assert rst in WAIT_HI -> lock=hs_req=gnt_vec=0 in same cycle (async), rr pointer=0.

Source files
------------

// File: rtl/lock_arb_master.sv
// Round-robin arbiter and 4-phase handshake master driving the async locker.
// One requester is granted per transaction. The grant drives lock and then hs_req.
// The locker's ack is synchronised into clk, and the handshake returns to zero before done pulses.
module lock_arb_master #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_vec,
  output logic [N_REQ-1:0] gnt_vec,
  output logic             done,
  output logic             lock,
  output logic             hs_req,
  input  logic             hs_ack,
  output logic             busy,
  output logic             err
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(TIMEOUT_CYC);
  localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_REQ,
    S_WAIT_HI,
    S_DROP,
    S_WAIT_LO,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic [PTR_W-1:0]       rr_ptr, rr_ptr_d;
  logic [PTR_W-1:0]       win_q, win_d;
  logic [PTR_W-1:0]       win_idx;
  logic                   win_found;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [N_REQ-1:0]       gnt_d;
  logic                   lock_d, hs_req_d, done_d, busy_d, err_d;

  // Bring the asynchronous locker ack into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], hs_ack};
    end
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

  // Find the first request at or above the rr pointer, wrapping from N_REQ-1 to 0.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = (32'(rr_ptr) + k) % N_REQ;
      if (!win_found && req_vec[cand]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(cand);
      end
    end
  end

  // The wait counter saturates so that a long stall cannot wrap and hide the timeout.
  assign cnt_inc = (cnt_q == TIMEOUT_MAX) ? cnt_q : cnt_q + 1'b1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Compute the next state and the next value of every registered output.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_vec;
    lock_d   = lock;
    hs_req_d = hs_req;
    done_d   = 1'b0;
    err_d    = err;
    cnt_d    = cnt_q;
    win_d    = win_q;
    rr_ptr_d = rr_ptr;
    unique case (state_q)
      S_IDLE: begin
        // A stale ack means the locker has not yet returned to zero, so no grant is made.
        if (win_found && !ack_s) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          win_d          = win_idx;
          state_d        = S_GRANT;
        end
      end
      S_GRANT: begin
        lock_d  = 1'b1;
        state_d = S_REQ;
      end
      S_REQ: begin
        hs_req_d = 1'b1;
        cnt_d    = '0;
        state_d  = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (ack_s) begin
          state_d = S_DROP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_MAX) err_d = 1'b1;
        end
      end
      S_DROP: begin
        // ack = req_out | lock, so both must fall together for ack to return to zero.
        hs_req_d = 1'b0;
        lock_d   = 1'b0;
        cnt_d    = '0;
        state_d  = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!ack_s) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_MAX) err_d = 1'b1;
        end
      end
      S_DONE: begin
        gnt_d    = '0;
        done_d   = 1'b1;
        rr_ptr_d = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Register the outputs and the arbitration and timeout bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_vec <= '0;
      lock    <= 1'b0;
      hs_req  <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      cnt_q   <= '0;
      win_q   <= '0;
      rr_ptr  <= '0;
    end else begin
      gnt_vec <= gnt_d;
      lock    <= lock_d;
      hs_req  <= hs_req_d;
      done    <= done_d;
      busy    <= busy_d;
      err     <= err_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      rr_ptr  <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_lock_arb_master.sv
// Directed bench for lock_arb_master.
// It covers reset, a single transaction timeline, round-robin order and wrap-around, stale ack,
// timeout and mid-transaction reset.
module tb_lock_arb_master;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_vec;
  logic [3:0] gnt_vec;
  logic       done, lock, hs_req, hs_ack, busy, err;

  // Locker model: ack = req | lock with zero delay, or a forced level.
  logic ack_auto, ack_force;
  assign hs_ack = ack_auto ? (hs_req | lock) : ack_force;

  int n_tests = 0;
  int n_fail  = 0;

  lock_arb_master #(
    .N_REQ      (4),
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req_vec(req_vec),
    .gnt_vec(gnt_vec),
    .done   (done),
    .lock   (lock),
    .hs_req (hs_req),
    .hs_ack (hs_ack),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output logic [3:0] g);
    int unsigned n;
    n = 0;
    while (gnt_vec == 4'b0 && n < 40) begin
      tick();
      n++;
    end
    check_eq("gnt_seen", 32'(|gnt_vec), 1);
    g = gnt_vec;
  endtask

  task automatic wait_done();
    int unsigned n;
    n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    check_eq("done_seen", 32'(done), 1);
  endtask

  task automatic do_txn(input logic [3:0] r, output logic [3:0] g);
    req_vec = r;
    wait_gnt(g);
    wait_done();
  endtask

  logic [3:0] g;
  logic [3:0] rr_exp   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] wrap_req [5] = '{4'b1000, 4'b1001, 4'b1001, 4'b0010, 4'b0011};
  logic [3:0] wrap_exp [5] = '{4'b1000, 4'b0001, 4'b1000, 4'b0010, 4'b0001};

  initial begin
    rst       = 1'b1;
    req_vec   = 4'hF;
    ack_auto  = 1'b1;
    ack_force = 1'b0;

    // Reset with all requests active keeps every output low.
    repeat (3) tick();
    check_eq("rst_gnt",    32'(gnt_vec), 0);
    check_eq("rst_done",   32'(done),    0);
    check_eq("rst_lock",   32'(lock),    0);
    check_eq("rst_hs_req", 32'(hs_req),  0);
    check_eq("rst_busy",   32'(busy),    0);
    check_eq("rst_err",    32'(err),     0);
    rst = 1'b0;
    tick();
    check_eq("first_gnt", 32'(gnt_vec), 32'h1);
    req_vec = 4'b0;
    wait_done();
    check_eq("first_gnt_clr", 32'(gnt_vec), 0);

    // Single transaction timeline; the request drops right after the grant.
    req_vec = 4'b0100;
    for (int c = 0; c <= 10; c++) begin
      tick();
      if (c == 0) req_vec = 4'b0;
      check_eq($sformatf("txn_gnt_c%0d", c),  32'(gnt_vec), (c <= 8) ? 32'h4 : 32'h0);
      check_eq($sformatf("txn_lock_c%0d", c), 32'(lock),   32'(c >= 1 && c <= 4));
      check_eq($sformatf("txn_req_c%0d", c),  32'(hs_req), 32'(c >= 2 && c <= 4));
      check_eq($sformatf("txn_done_c%0d", c), 32'(done),   32'(c == 9));
      check_eq($sformatf("txn_busy_c%0d", c), 32'(busy),   32'(c <= 8));
    end

    // Round-robin order from a freshly reset pointer, then wrap-around cases.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_txn(4'hF, g);
      check_eq($sformatf("rr_%0d", i), 32'(g), 32'(rr_exp[i]));
    end
    for (int i = 0; i < 5; i++) begin
      do_txn(wrap_req[i], g);
      check_eq($sformatf("wrap_%0d", i), 32'(g), 32'(wrap_exp[i]));
    end
    req_vec = 4'b0;

    // A stale ack in IDLE blocks grants until the synchronised ack is low.
    ack_auto  = 1'b0;
    ack_force = 1'b1;
    repeat (3) tick();
    req_vec = 4'b0001;
    repeat (4) tick();
    check_eq("stale_gnt",  32'(gnt_vec), 0);
    check_eq("stale_busy", 32'(busy),    0);
    ack_force = 1'b0;
    tick();
    check_eq("stale_gnt_a", 32'(gnt_vec), 0);
    tick();
    check_eq("stale_gnt_b", 32'(gnt_vec), 0);
    tick();
    check_eq("stale_gnt_c", 32'(gnt_vec), 32'h1);
    ack_auto = 1'b1;
    req_vec  = 4'b0;
    wait_done();

    // Timeout: ack stuck low sets err after 8 WAIT_HI cycles, and the transaction still completes.
    ack_auto  = 1'b0;
    ack_force = 1'b0;
    req_vec   = 4'b0010;
    for (int c = 0; c <= 12; c++) begin
      tick();
      if (c == 0) begin
        req_vec = 4'b0;
        check_eq("to_gnt", 32'(gnt_vec), 32'h2);
      end
      if (c == 9)  check_eq("to_err_before", 32'(err), 0);
      if (c == 10) check_eq("to_err_set",    32'(err), 1);
    end
    check_eq("to_lock_held", 32'(lock),   1);
    check_eq("to_req_held",  32'(hs_req), 1);
    check_eq("to_busy",      32'(busy),   1);
    ack_auto = 1'b1;
    wait_done();
    check_eq("to_err_sticky", 32'(err), 1);

    // Reset in WAIT_HI clears the outputs asynchronously and resets the rr pointer.
    ack_auto  = 1'b0;
    ack_force = 1'b0;
    req_vec   = 4'b0100;
    repeat (3) tick();
    check_eq("mid_req_up", 32'(hs_req), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_lock", 32'(lock),    0);
    check_eq("mid_req",  32'(hs_req),  0);
    check_eq("mid_gnt",  32'(gnt_vec), 0);
    check_eq("mid_busy", 32'(busy),    0);
    check_eq("mid_err",  32'(err),     0);
    ack_auto = 1'b1;
    req_vec  = 4'hF;
    tick();
    rst = 1'b0;
    tick();
    check_eq("mid_ptr0", 32'(gnt_vec), 32'h1);
    req_vec = 4'b0;
    wait_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Bound the whole run so it always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
